alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Command sequencer that drives the 8-bit ALU/CPU core's load interface from a small host-programmed command table. It feeds the core's `data_in`/`opcode`/`cin`/`load` inputs and consumes its `data_out`/`cout`. For each table entry it presents operand A, then operand B, with single-cycle `load` strobes. It then waits a fixed result latency and captures the result and carry into a readable result buffer. It sits between the host/test logic and the CPU core.

## Interface
Parameters:
- `DEPTH`, 8: command table and result buffer entries (power of two, ≥2)
- `RESULT_LAT`, 1: cycles from the second `load` strobe to a valid `cpu_data_out` (≥1)

Ports:
- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: run request, sampled only in IDLE
- `count` in $clog2(DEPTH)+1: number of entries to run, 0..DEPTH; latched on start
- `busy` out 1: sequence in progress
- `done` out 1: one-cycle completion pulse
- `prog_we` in 1: table write strobe
- `prog_addr` in $clog2(DEPTH): table write index
- `prog_opcode` in 8: opcode for the entry
- `prog_a` in 8: first operand for the entry
- `prog_b` in 8: second operand for the entry
- `prog_cin` in 1: carry-in for the entry
- `cpu_data_in` out 8: operand bus to the core
- `cpu_opcode` out 8: opcode to the core
- `cpu_cin` out 1: carry-in to the core
- `cpu_load` out 1: operand load strobe to the core
- `cpu_data_out` in 8: result from the core
- `cpu_cout` in 1: carry-out from the core
- `res_addr` in $clog2(DEPTH): result read index
- `res_data` out 8: result at `res_addr`, combinational read
- `res_carry` out 1: carry at `res_addr`, combinational read

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, WAIT, DONE.
- IDLE, `start`=1:
  - `count`=0: go to DONE; no strobes issued.
  - otherwise: latch `count`, set idx=0, go to LOAD_A.
- LOAD_A: `cpu_data_in`=A[idx], `cpu_load`=1. Go to LOAD_B.
- LOAD_B: `cpu_data_in`=B[idx], `cpu_load`=1. Go to WAIT; clear the wait counter.
- WAIT: run for RESULT_LAT cycles. On the last WAIT cycle's edge:
  - capture `cpu_data_out`/`cpu_cout` into result[idx]/carry[idx];
  - if idx==count-1, go to DONE; otherwise increment idx and go to LOAD_A.
- DONE: `done`=1 for one cycle, then IDLE.
- `cpu_opcode`/`cpu_cin` equal entry idx's values from LOAD_A through WAIT, and 0 in IDLE/DONE.
- `cpu_data_in`=0 and `cpu_load`=0 outside LOAD_A/LOAD_B.
- `busy`=1 in LOAD_A/LOAD_B/WAIT only.
- `prog_we` is honoured in IDLE/DONE and ignored while `busy`.
- `start` is ignored outside IDLE, including in DONE.
- Result entries not run in the current sequence keep their previous values.
- Reset (asynchronous, any state, including mid-sequence): FSM to IDLE. All outputs 0: `busy`, `done`, `cpu_*`, result/carry buffers, checksum. The command table is also cleared to 0.

## Timing
- `start` sampled at edge 0; LOAD_A is cycle 1, LOAD_B is cycle 2.
- Capture occurs at the end of cycle 2+RESULT_LAT.
- Per entry: 2+RESULT_LAT cycles.
- `done` asserts in cycle count·(2+RESULT_LAT)+1. With `count`=0, `done` asserts in cycle 1.
- A new `start` is accepted at the earliest in the cycle after DONE.
- A captured result is visible on `res_data` the cycle after the capture edge.

## Configuration
- `ALU_SEQ_CHKSUM_EN` defined:
  - adds output port `chksum` (out, 8);
  - cleared to 0 when `start` is accepted;
  - XOR-accumulates every captured result at its capture edge;
  - stable from DONE until the next start.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Shared package `alu_seq_pkg`: FSM state enum, `OPW`=8 and `DATAW`=8 constants, the command-entry struct {opcode, a, b, cin}.
- One sub-module, `alu_seq_table`: DEPTH-entry register file. Synchronous write, asynchronous read, asynchronous clear. Instantiated twice: once for commands, once for results (8-bit result plus carry).

## Test plan
- Program entry 0 = {op 0x01, A 0x05, B 0x03, cin 0}; model core returns 0x08/cout 0; count=1, start → `load` high in cycles 1–2 with `data_in` 0x05 then 0x03; `done` in cycle 4; res[0]=0x08, carry 0.
- Program 4 entries; count=4 → eight `load` pulses; `done` in cycle 13; all four results correct; with `ALU_SEQ_CHKSUM_EN`, `chksum` equals the XOR of the four results.
- count=0, start → no `load` pulse; `done` in cycle 1; result buffer unchanged.
- `prog_we` to entry 1 and `start` asserted mid-run → table and sequence unaffected; the run completes with the original values.
- Assert `rst_n`=0 during WAIT of entry 2 → immediately `busy`/`cpu_load`=0; result buffer 0; after release, a fresh start runs normally.
- RESULT_LAT=3, model core with 3-cycle latency, count=2 → `done` in cycle 11; results captured from the correct cycles, not from stale data.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
//   seq_state_t  : sequencer FSM states
//   OPW / DATAW  : opcode and data widths of the ALU core interface
//   cmd_entry_t  : one command-table entry {opcode, a, b, cin}
// Optional feature macro: ALU_SEQ_CHKSUM_EN (adds the chksum output on the top).
package alu_seq_pkg;

  localparam int OPW   = 8;
  localparam int DATAW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [OPW-1:0]   opcode;
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    logic             cin;
  } cmd_entry_t;

  localparam int CMD_W = $bits(cmd_entry_t);

endpackage

// File: rtl/alu_seq_table.sv
// DEPTH-entry register file: synchronous write, asynchronous read,
// asynchronous clear of every entry on reset.
//   clk, rst_n : clock, async active-low reset (clears contents)
//   we, waddr, wdata : write port, captured on the rising edge
//   raddr, rdata     : combinational read port
module alu_seq_table
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATAW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer feeding the 8-bit ALU core's load interface from a
// host-programmed command table. Each entry is issued as operand A then
// operand B on single-cycle load strobes; after RESULT_LAT cycles the core's
// result and carry are captured into a result buffer.
//   clk, rst_n          : clock, async active-low reset
//   start, count        : run request (IDLE only) and number of entries
//   busy, done          : sequence in progress, one-cycle completion pulse
//   prog_*              : command-table write port (ignored while busy)
//   cpu_data_in/opcode/cin/load : drive to the core
//   cpu_data_out/cout   : result from the core
//   res_addr, res_data, res_carry : combinational result-buffer read
// Optional: define ALU_SEQ_CHKSUM_EN to add output chksum, the XOR of all
// results captured since the last accepted start.
//
// state    | meaning
// S_IDLE   | waiting for start; command table writable
// S_LOAD_A | operand A of entry idx on cpu_data_in, load strobe
// S_LOAD_B | operand B of entry idx on cpu_data_in, load strobe
// S_WAIT   | waiting RESULT_LAT cycles; capture on the last one
// S_DONE   | one-cycle done pulse; command table writable
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int RESULT_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [OPW-1:0]           prog_opcode,
  input  logic [DATAW-1:0]         prog_a,
  input  logic [DATAW-1:0]         prog_b,
  input  logic                     prog_cin,
  output logic [DATAW-1:0]         cpu_data_in,
  output logic [OPW-1:0]           cpu_opcode,
  output logic                     cpu_cin,
  output logic                     cpu_load,
  input  logic [DATAW-1:0]         cpu_data_out,
  input  logic                     cpu_cout,
  input  logic [$clog2(DEPTH)-1:0] res_addr,
  output logic [DATAW-1:0]         res_data,
  output logic                     res_carry
`ifdef ALU_SEQ_CHKSUM_EN
  ,
  output logic [DATAW-1:0]         chksum
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  // wait counter only ever holds RESULT_LAT-1 down to 0
  localparam int WCW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
  localparam int RW  = DATAW + 1;

  seq_state_t       state, state_nxt;
  logic [AW-1:0]    idx;
  logic [CW-1:0]    count_q;
  logic [WCW-1:0]   wait_cnt;

  cmd_entry_t       cmd_wdata, cmd_rdata;
  logic             cmd_we;
  logic [RW-1:0]    res_wdata, res_rdata;
  logic             capture;
  logic             last_entry;

  // table writes only land while no sequence is reading the table
  assign cmd_we     = prog_we && !busy;
  assign cmd_wdata  = '{opcode: prog_opcode, a: prog_a, b: prog_b, cin: prog_cin};
  assign capture    = (state == S_WAIT) && (wait_cnt == '0);
  assign last_entry = (CW'(idx) == (count_q - CW'(1)));
  assign res_wdata  = {cpu_cout, cpu_data_out};
  assign res_data   = res_rdata[DATAW-1:0];
  assign res_carry  = res_rdata[DATAW];

  alu_seq_table #(.DEPTH(DEPTH), .WIDTH(CMD_W)) u_cmd_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cmd_we),
    .waddr (prog_addr),
    .wdata (cmd_wdata),
    .raddr (idx),
    .rdata (cmd_rdata)
  );

  alu_seq_table #(.DEPTH(DEPTH), .WIDTH(RW)) u_res_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (capture),
    .waddr (idx),
    .wdata (res_wdata),
    .raddr (res_addr),
    .rdata (res_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      count_q  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start && (count != '0)) begin
            count_q <= count;
            idx     <= '0;
          end
        end
        S_LOAD_B: wait_cnt <= WCW'(RESULT_LAT - 1);
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WCW'(1);
          end else if (!last_entry) begin
            idx <= idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    cpu_data_in = '0;
    cpu_opcode  = '0;
    cpu_cin     = 1'b0;
    cpu_load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (count == '0) ? S_DONE : S_LOAD_A;
      end
      S_LOAD_A: begin
        busy        = 1'b1;
        cpu_load    = 1'b1;
        cpu_data_in = cmd_rdata.a;
        cpu_opcode  = cmd_rdata.opcode;
        cpu_cin     = cmd_rdata.cin;
        state_nxt   = S_LOAD_B;
      end
      S_LOAD_B: begin
        busy        = 1'b1;
        cpu_load    = 1'b1;
        cpu_data_in = cmd_rdata.b;
        cpu_opcode  = cmd_rdata.opcode;
        cpu_cin     = cmd_rdata.cin;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        busy       = 1'b1;
        cpu_opcode = cmd_rdata.opcode;
        cpu_cin    = cmd_rdata.cin;
        if (capture) state_nxt = last_entry ? S_DONE : S_LOAD_A;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef ALU_SEQ_CHKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chksum <= '0;
    end else if ((state == S_IDLE) && start) begin
      chksum <= '0;
    end else if (capture) begin
      chksum <= chksum ^ cpu_data_out;
    end
  end
`endif

endmodule
